// File: rtl/keypad_encoder_db_if.sv
// keypad_encoder_db_if: raw button inputs and encoded key/control outputs of the keypad front end
interface keypad_encoder_db_if #(
  parameter int NUM_KEYS = 13,
  parameter int NUM_CTRL = 2,
  parameter int KW       = $clog2(NUM_KEYS + 1)
);
  logic [NUM_KEYS-1:0] pb_keys;
  logic [NUM_CTRL-1:0] pb_ctrl;
  logic [KW-1:0]       keycode;
  logic                key_valid;
  logic                key_press;
  logic                key_release;
  logic [NUM_CTRL-1:0] ctrl_level;
  logic [NUM_CTRL-1:0] ctrl_edge;
  modport master (
    output pb_keys, pb_ctrl,
    input  keycode, key_valid, key_press, key_release, ctrl_level, ctrl_edge
  );
  modport slave (
    input  pb_keys, pb_ctrl,
    output keycode, key_valid, key_press, key_release, ctrl_level, ctrl_edge
  );
endinterface

// File: rtl/keypad_encoder_db.sv
// keypad_encoder_db: synchronise and debounce push-buttons, priority-encode note keys, pulse control edges
module keypad_encoder_db #(
  parameter int NUM_KEYS        = 13,
  parameter int NUM_CTRL        = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int KW              = $clog2(NUM_KEYS + 1)
) (
  input logic clk,
  input logic n_rst,
  keypad_encoder_db_if.slave bus
);
  localparam int N  = NUM_KEYS + NUM_CTRL;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic [N-1:0]        r_sync [SYNC_STAGES];
  logic [N-1:0]        r_stb;
  logic [CW-1:0]       r_cnt [N];
  logic [N-1:0]        w_raw;
  logic [N-1:0]        w_sync;
  logic [NUM_KEYS-1:0] w_stb_keys;
  logic [NUM_CTRL-1:0] w_stb_ctrl;
  logic [KW-1:0]       w_code;
  logic                w_valid;
  logic [KW-1:0]       r_keycode;
  logic                r_key_valid;
  logic                r_key_press;
  logic                r_key_release;
  logic [NUM_CTRL-1:0] r_ctrl_level;
  logic [NUM_CTRL-1:0] r_ctrl_edge;
  assign w_raw      = {bus.pb_ctrl, bus.pb_keys};
  assign w_sync     = r_sync[SYNC_STAGES-1];
  assign w_stb_keys = r_stb[NUM_KEYS-1:0];
  assign w_stb_ctrl = r_stb[N-1:NUM_KEYS];
  // shift raw buttons through the synchroniser chain
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= w_raw;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end
  // per-input debounce: flip the stable bit only after DEBOUNCE_CYCLES consecutive mismatches
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_stb <= '0;
      for (int i = 0; i < N; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_sync[i] == r_stb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_stb[i] <= w_sync[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end
  // lowest pressed index wins; all-ones marks no key
  always_comb begin
    w_code = '1;
    for (int i = NUM_KEYS - 1; i >= 0; i--) if (w_stb_keys[i]) w_code = KW'(i);
    w_valid = |w_stb_keys;
  end
  // register encoded key state, press/release events and control edges
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_keycode     <= '1;
      r_key_valid   <= 1'b0;
      r_key_press   <= 1'b0;
      r_key_release <= 1'b0;
      r_ctrl_level  <= '0;
      r_ctrl_edge   <= '0;
    end else begin
      r_keycode     <= w_code;
      r_key_valid   <= w_valid;
      r_key_press   <= w_valid & (w_code != r_keycode);
      r_key_release <= r_key_valid & ~w_valid;
      r_ctrl_level  <= w_stb_ctrl;
      r_ctrl_edge   <= w_stb_ctrl & ~r_ctrl_level;
    end
  end
  assign bus.keycode     = r_keycode;
  assign bus.key_valid   = r_key_valid;
  assign bus.key_press   = r_key_press;
  assign bus.key_release = r_key_release;
  assign bus.ctrl_level  = r_ctrl_level;
  assign bus.ctrl_edge   = r_ctrl_edge;
endmodule

// File: tb/tb_keypad_encoder_db.sv
// tb_keypad_encoder_db: directed vectors with hand-computed expectations for the keypad front end
module tb_keypad_encoder_db;
  logic clk;
  logic n_rst;
  int n_vec, n_err, cyc;
  int n_press, n_rel, n_ce0, n_ce1, last_press_cyc, mark;
  logic [3:0] last_code;
  keypad_encoder_db_if #(.NUM_KEYS(13), .NUM_CTRL(2)) bus ();
  keypad_encoder_db #(
    .NUM_KEYS(13), .NUM_CTRL(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .bus(bus.slave)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic clr();
    n_press = 0;
    n_rel = 0;
    n_ce0 = 0;
    n_ce1 = 0;
    last_press_cyc = -1;
    last_code = 4'h0;
  endtask
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.key_press) begin
        n_press++;
        last_code = bus.keycode;
        last_press_cyc = cyc;
      end
      if (bus.key_release) n_rel++;
      if (bus.ctrl_edge[0]) n_ce0++;
      if (bus.ctrl_edge[1]) n_ce1++;
      if (bus.key_press && bus.key_release) chk("press_and_release", 1, 0);
    end
  endtask
  initial begin
    n_vec = 0;
    n_err = 0;
    cyc = 0;
    clr();
    n_rst = 1'b0;
    bus.pb_keys = '0;
    bus.pb_ctrl = '0;
    #12;
    chk("rst_keycode", bus.keycode, 4'hF);
    chk("rst_valid", bus.key_valid, 0);
    chk("rst_press", bus.key_press, 0);
    chk("rst_release", bus.key_release, 0);
    chk("rst_level", bus.ctrl_level, 0);
    chk("rst_edge", bus.ctrl_edge, 0);
    n_rst = 1'b1;
    run(3);
    // single press of key 4
    clr();
    bus.pb_keys[4] = 1'b1;
    run(6);
    chk("k4_early_press", bus.key_press, 0);
    chk("k4_early_code", bus.keycode, 4'hF);
    run(1);
    chk("k4_code", bus.keycode, 4'h4);
    chk("k4_valid", bus.key_valid, 1);
    chk("k4_press", bus.key_press, 1);
    run(1);
    chk("k4_press_once", bus.key_press, 0);
    run(10);
    chk("k4_press_count", n_press, 1);
    bus.pb_keys[4] = 1'b0;
    run(7);
    chk("k4_release", bus.key_release, 1);
    chk("k4_rel_code", bus.keycode, 4'hF);
    chk("k4_rel_valid", bus.key_valid, 0);
    run(1);
    chk("k4_release_once", bus.key_release, 0);
    run(5);
    chk("k4_rel_count", n_rel, 1);
    // glitch rejection on key 2
    clr();
    bus.pb_keys[2] = 1'b1;
    run(3);
    bus.pb_keys[2] = 1'b0;
    run(12);
    chk("glitch_press", n_press, 0);
    chk("glitch_code", bus.keycode, 4'hF);
    chk("glitch_valid", bus.key_valid, 0);
    bus.pb_keys[2] = 1'b1;
    run(4);
    bus.pb_keys[2] = 1'b0;
    run(15);
    chk("pulse4_press", n_press, 1);
    chk("pulse4_code", last_code, 4'h2);
    chk("pulse4_rel", n_rel, 1);
    // priority between keys 7 and 3
    clr();
    bus.pb_keys[7] = 1'b1;
    bus.pb_keys[3] = 1'b1;
    run(7);
    chk("pri_code", bus.keycode, 4'h3);
    chk("pri_press", bus.key_press, 1);
    run(5);
    bus.pb_keys[3] = 1'b0;
    run(7);
    chk("pri_switch_code", bus.keycode, 4'h7);
    chk("pri_switch_press", bus.key_press, 1);
    chk("pri_switch_rel", bus.key_release, 0);
    run(3);
    bus.pb_keys[7] = 1'b0;
    run(7);
    chk("pri_final_rel", bus.key_release, 1);
    run(3);
    chk("pri_press_count", n_press, 2);
    chk("pri_rel_count", n_rel, 1);
    // adding a higher index while a lower one is held gives no press
    bus.pb_keys[3] = 1'b1;
    run(10);
    clr();
    bus.pb_keys[5] = 1'b1;
    run(10);
    chk("add_hi_press", n_press, 0);
    chk("add_hi_code", bus.keycode, 4'h3);
    bus.pb_keys = '0;
    run(10);
    // control buttons
    clr();
    bus.pb_ctrl = 2'b01;
    run(7);
    chk("c0_edge", bus.ctrl_edge, 2'b01);
    chk("c0_level", bus.ctrl_level, 2'b01);
    run(1);
    chk("c0_edge_once", bus.ctrl_edge, 2'b00);
    run(12);
    chk("c0_level_hold", bus.ctrl_level, 2'b01);
    chk("c0_edge_count", n_ce0, 1);
    clr();
    bus.pb_ctrl = 2'b11;
    bus.pb_keys[12] = 1'b1;
    run(7);
    chk("c1_edge", bus.ctrl_edge, 2'b10);
    chk("c1_key_press", bus.key_press, 1);
    chk("c1_keycode", bus.keycode, 4'hC);
    run(3);
    // asynchronous reset mid-operation
    #3 n_rst = 1'b0;
    #1;
    chk("arst_keycode", bus.keycode, 4'hF);
    chk("arst_valid", bus.key_valid, 0);
    chk("arst_press", bus.key_press, 0);
    chk("arst_release", bus.key_release, 0);
    chk("arst_level", bus.ctrl_level, 0);
    chk("arst_edge", bus.ctrl_edge, 0);
    #1 n_rst = 1'b1;
    clr();
    mark = cyc;
    run(10);
    chk("arst_relatency", last_press_cyc - mark, 7);
    chk("arst_recode", last_code, 4'hC);
    chk("arst_ce0", n_ce0, 1);
    chk("arst_ce1", n_ce1, 1);
    bus.pb_keys = '0;
    bus.pb_ctrl = '0;
    run(12);
    // bounce train on key 0
    clr();
    for (int k = 0; k < 15; k++) begin
      bus.pb_keys[0] = ~bus.pb_keys[0];
      if (k < 14) run(2);
    end
    mark = cyc;
    run(20);
    chk("bounce_press_count", n_press, 1);
    chk("bounce_latency", last_press_cyc - mark, 7);
    chk("bounce_code", last_code, 4'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
